serial_pattern_detector: RTL and testbench
==========================================

// Module: serial_pattern_detector
// PURPOSE
//  - Consumes the serial bit stream produced by the D flip-flop stage (its q drives din here).
//  - Shifts in one bit per qualified clock into a PATTERN_W-bit window.
//  - Pulses match for one cycle when the window equals PATTERN.
//  - Keeps a saturating count of matches for lab observation.
// PARAMETERS
//  - PATTERN_W  4        window / pattern length in bits (>=2)
//  - PATTERN    4'b1011  target sequence; MSB = oldest bit received
//  - CNT_W      8        width of match_count
// PORTS
//  - clk          in   1          rising-edge clock; the only clock
//  - reset        in   1          synchronous, active-high reset
//  - din          in   1          serial data bit (from flip-flop q)
//  - din_valid    in   1          qualifies din on this rising edge
//  - match        out  1          one-cycle pulse: pattern just completed
//  - match_count  out  CNT_W      saturating number of matches
//  - window       out  PATTERN_W  current shift window, MSB oldest (debug)
// BEHAVIOUR
//  - Reset: sampled on rising clk; has priority over all other inputs.
//    - window=0, fill=0, state=FILL, match=0, match_count=0.
//  - Accept: a rising edge with din_valid=1 and reset=0.
//    - window_n = {window[PATTERN_W-2:0], din}
//    - fill_n   = min(fill+1, PATTERN_W)
//  - din_valid=0: window, fill and state hold; match<=0.
//  - FSM states:
//    - FILL: fewer than PATTERN_W valid bits received since reset/match; no match possible.
//      Moves to RUN when fill_n==PATTERN_W.
//    - RUN: window is fully populated. Compares window_n against PATTERN on every accept.
//  - Match condition: on an accept where fill_n==PATTERN_W and window_n==PATTERN.
//    - match<=1, registered: it is high during the cycle after the accepting edge.
//    - On every other edge, match<=0. No combinational input-to-output path.
//  - match_count increments on each match edge and saturates at 2^CNT_W-1 (no wrap).
//  - Stale reset contents of window never cause a match; fill gating is mandatory.
//  - Gaps in din_valid of any length do not break a partially received pattern.
//  - Reset asserted mid-pattern discards all partial progress.
// CONFIGURATION
//  - Macro SEQ_OVERLAP_EN.
//  - Defined: overlapping detection.
//    - After a match, state stays RUN and fill stays PATTERN_W.
//    - Window bits are reused, so the next match can complete on the very next accept.
//  - Undefined (default): non-overlapping detection.
//    - On the match edge, window<=0, fill<=0 and state<=FILL.
//    - A full PATTERN_W new valid bits are needed before the next match.
// STRUCTURE
//  - Package serial_det_pkg holds:
//    - typedef enum logic {FILL, RUN} det_state_t
//    - localparam DEFAULT_PATTERN = 4'b1011
//  - Sub-module shift_window (PATTERN_W D flip-flops with enable and sync clear).
//    Instantiated once; holds window. FSM, fill counter and match counter stay in the top.
// TESTING
//  - T1 basic: PATTERN=1011; accept 1,0,1,1 on consecutive edges
//    -> match=1 for exactly one cycle after 4th edge; match_count=1.
//  - T2 overlap: accept 1,0,1,1,0,1,1
//    -> without SEQ_OVERLAP_EN: 1 match, count=1.
//    -> with SEQ_OVERLAP_EN: 2 matches (after edges 4 and 7), count=2.
//  - T3 valid gaps: 1,0,(3 idle),1,(1 idle),1
//    -> match low during idles; single pulse after last accept; count=1.
//  - T4 reset mid-pattern: accept 1,0,1, assert reset 1 cycle, accept 1
//    -> no match; count=0; window=0001.
//  - T5 fill gating: PATTERN=0011; after reset accept 1,1
//    -> window=0011 but no match (fill=2); then accept 0,0,1,1 -> match.
//  - T6 saturation: CNT_W=2; drive 5 non-overlapping 1011 patterns
//    -> 5 match pulses; match_count stops at 3.

Source files
------------

// File: rtl/serial_pattern_detector_pkg.sv
// Shared types and defaults for the serial pattern detector.
// The overlap behaviour is selected by the SEQ_OVERLAP_EN macro in the top module.
package serial_det_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } det_state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

   // Number of bits needed to hold a fill count in the range 0..n.
   function automatic int fill_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/serial_pattern_detector_shift_window.sv
// PATTERN_W-bit serial shift window: new bits enter at the LSB, MSB is the oldest.
// Synchronous clear (reset or match restart) has priority over shifting.
module shift_window #(
   parameter int PATTERN_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic                 din,
   output logic [PATTERN_W-1:0] window
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         window <= '0;
      end else if (enable) begin
         window <= {window[PATTERN_W-2:0], din};
      end
   end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts qualified bits into a window and pulses match when it equals PATTERN.
// Define SEQ_OVERLAP_EN for overlapping detection; the default build restarts the window after each match.
module serial_pattern_detector
   import serial_det_pkg::*;
#(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEFAULT_PATTERN),
   parameter int                   CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 din,
   input  logic                 din_valid,
   output logic                 match,
   output logic [CNT_W-1:0]     match_count,
   output logic [PATTERN_W-1:0] window
);

   localparam int               FILL_W    = fill_width(PATTERN_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   det_state_t            state;
   det_state_t            state_next;
   logic [FILL_W-1:0]     fill;
   logic [FILL_W-1:0]     fill_next;
   logic [FILL_W-1:0]     fill_inc;
   logic [PATTERN_W-1:0]  window_n;
   logic                  win_shift;
   logic                  win_clear;
   logic                  match_next;
   logic [CNT_W-1:0]      count_next;

   shift_window #(
      .PATTERN_W (PATTERN_W)
   ) u_shift_window (
      .clk    (clk),
      .reset  (reset),
      .clear  (win_clear),
      .enable (win_shift),
      .din    (din),
      .window (window)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FILL;
         fill        <= '0;
         match       <= 1'b0;
         match_count <= '0;
      end else begin
         state       <= state_next;
         fill        <= fill_next;
         match       <= match_next;
         match_count <= count_next;
      end
   end

   // A match needs a fully populated window so stale reset zeros can never match.
   always_comb begin
      state_next = state;
      fill_next  = fill;
      win_shift  = 1'b0;
      win_clear  = 1'b0;
      match_next = 1'b0;
      count_next = match_count;
      window_n   = {window[PATTERN_W-2:0], din};
      fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);

      if (din_valid) begin
         win_shift = 1'b1;
         fill_next = fill_inc;
         case (state)
            FILL:    if (fill_inc == FILL_FULL) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = FILL;
         endcase

         if ((fill_inc == FILL_FULL) && (window_n == PATTERN)) begin
            match_next = 1'b1;
            if (match_count != CNT_MAX) begin
               count_next = match_count + CNT_W'(1);
            end
`ifdef SEQ_OVERLAP_EN
            state_next = RUN;
`else
            win_shift  = 1'b0;
            win_clear  = 1'b1;
            fill_next  = '0;
            state_next = FILL;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Scoreboard bench: two detector instances (default, and PATTERN=0011 with CNT_W=2) share one random stream.
// The model keeps the accepted bit history as a queue and matches on its tail.
module tb_serial_pattern_detector;

   localparam logic [3:0] PAT_A = 4'b1011;
   localparam logic [3:0] PAT_B = 4'b0011;
   localparam int         MAX_A = 255;
   localparam int         MAX_B = 3;

   typedef struct packed {
      logic       m;
      logic [7:0] cnt;
      logic [3:0] win;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;

   logic       matchA, matchB;
   logic [7:0] countA;
   logic [1:0] countB;
   logic [3:0] windowA, windowB;

   exp_t expA[$];
   exp_t expB[$];
   bit   histA[$];
   bit   histB[$];
   int   cntA = 0;
   int   cntB = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   serial_pattern_detector dutA (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .match       (matchA),
      .match_count (countA),
      .window      (windowA)
   );

   serial_pattern_detector #(
      .PATTERN_W (4),
      .PATTERN   (PAT_B),
      .CNT_W     (2)
   ) dutB (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .match       (matchB),
      .match_count (countB),
      .window      (windowB)
   );

   function automatic logic [3:0] tailBits(input bit q[$]);
      logic [3:0] w = '0;
      for (int i = 0; i < q.size() && i < 4; i++) w[i] = q[q.size() - 1 - i];
      return w;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle, then advance the model by the edge it just saw.
   task automatic applyStimulus(input bit r, input bit v, input bit d);
      bit mA, mB;
      @(negedge clk);
      reset     = r;
      din_valid = v;
      din       = d;
      @(posedge clk);
      mA = 1'b0;
      mB = 1'b0;
      if (r) begin
         histA.delete(); histB.delete();
         cntA = 0; cntB = 0;
      end else if (v) begin
         histA.push_back(d);
         histB.push_back(d);
         if (histA.size() >= 4 && tailBits(histA) == PAT_A) begin
            mA = 1'b1;
            if (cntA < MAX_A) cntA++;
`ifndef SEQ_OVERLAP_EN
            histA.delete();
`endif
         end
         if (histB.size() >= 4 && tailBits(histB) == PAT_B) begin
            mB = 1'b1;
            if (cntB < MAX_B) cntB++;
`ifndef SEQ_OVERLAP_EN
            histB.delete();
`endif
         end
         if (histA.size() > 4) void'(histA.pop_front());
         if (histB.size() > 4) void'(histB.pop_front());
      end
      expA.push_back('{m: mA, cnt: 8'(cntA), win: tailBits(histA)});
      expB.push_back('{m: mB, cnt: 8'(cntB), win: tailBits(histB)});
   endtask

   task automatic sendBits(input logic [3:0] bits);
      for (int i = 3; i >= 0; i--) applyStimulus(1'b0, 1'b1, bits[i]);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expA.size() > 0) begin
            e = expA.pop_front();
            checkOutput("A.match", 32'(matchA), 32'(e.m));
            checkOutput("A.count", 32'(countA), 32'(e.cnt));
            checkOutput("A.window", 32'(windowA), 32'(e.win));
         end
         if (expB.size() > 0) begin
            e = expB.pop_front();
            checkOutput("B.match", 32'(matchB), 32'(e.m));
            checkOutput("B.count", 32'(countB), 32'(e.cnt));
            checkOutput("B.window", 32'(windowB), 32'(e.win));
         end
      end
   end

   initial begin : stimulus
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      // basic and overlapping stream
      sendBits(4'b1011);
      applyStimulus(0, 1, 0); applyStimulus(0, 1, 1); applyStimulus(0, 1, 1);
      applyStimulus(0, 0, 1);
      // gaps in din_valid
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 1); applyStimulus(0, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, i[0]);
      applyStimulus(0, 1, 1); applyStimulus(0, 0, 0); applyStimulus(0, 1, 1);
      applyStimulus(0, 0, 1);
      // reset mid-pattern
      applyStimulus(0, 1, 1); applyStimulus(0, 1, 0); applyStimulus(0, 1, 1);
      applyStimulus(1, 1, 1);
      applyStimulus(0, 1, 1);
      // fill gating on the 0011 instance
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 1); applyStimulus(0, 1, 1);
      sendBits(4'b0011);
      // counter saturation on the 2-bit instance
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 5; i++) sendBits(4'b0011);
      // counter saturation on the 8-bit instance
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 260; i++) sendBits(4'b1011);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
      // random traffic with sparse resets
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1);
      end
      @(posedge clk);
      #2;
      if (expA.size() != 0 || expB.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expA.size() + expB.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
